counter_mod: RTL and testbench

//   Parametrised modulo up/down counter with prescaler, synchronous load/clear,

---
 rtl/counter_mod.sv | 101 ++++++++++
 tb/tb_counter_mod.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/counter_mod.sv
// counter_mod: modulo up/down counter with prescaler, synchronous clear/load,
// wrap or saturate at the boundary, terminal-count level and overflow pulse.
// Single clock, synchronous active-low reset.
module counter_mod #(
  parameter int WIDTH    = 8,
  parameter int MODULO   = 256,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] val,
  output logic             tc,
  output logic             ovf
);

  // Prescaler needs at least one bit even when PRESCALE==1 (it then stays 0).
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Largest legal count; MODULO==2**WIDTH still fits in WIDTH bits here.
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULO - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  // Modulo held one bit wider so 2**WIDTH is representable for the clamp.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULO);

  logic [WIDTH-1:0] r_val;
  logic [PW-1:0]    r_pre;
  logic             r_ovf;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_boundary;
  logic             w_pre_last;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_step_val;

  assign w_at_max   = (r_val == MAX_VAL);
  assign w_at_zero  = (r_val == '0);
  assign w_boundary = up_dn ? w_at_max : w_at_zero;
  assign w_pre_last = (r_pre == PRE_LAST);

  assign val = r_val;
  assign ovf = r_ovf;
  assign tc  = w_boundary;

  // Clamp an out-of-range load value to the top of the count range.
  always_comb begin
    w_load_clamped = MAX_VAL;
    if ({1'b0, load_val} < MOD_EXT) begin
      w_load_clamped = load_val;
    end
  end

  // Value after one count step; the boundary compare keeps the adder in range.
  always_comb begin
    w_step_val = r_val;
    if (w_boundary) begin
      if (SATURATE == 0) begin
        w_step_val = up_dn ? '0 : MAX_VAL;
      end
    end else if (up_dn) begin
      w_step_val = r_val + WIDTH'(1);
    end else begin
      w_step_val = r_val - WIDTH'(1);
    end
  end

  // Count state: priority is reset, clear, load, then enabled counting.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_val <= '0;
      r_pre <= '0;
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_val <= '0;
      r_pre <= '0;
      r_ovf <= 1'b0;
    end else if (load) begin
      r_val <= w_load_clamped;
      r_pre <= '0;
      r_ovf <= 1'b0;
    end else if (en) begin
      if (w_pre_last) begin
        r_pre <= '0;
        r_val <= w_step_val;
        r_ovf <= w_boundary;
      end else begin
        r_pre <= r_pre + PW'(1);
        r_ovf <= 1'b0;
      end
    end else begin
      r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_mod.sv
// tb_counter_mod: four counter_mod configurations driven by shared stimulus
// (wrap, saturate, prescale-3, full 2**WIDTH range) checked against a
// behavioural model every cycle, plus hand-computed directed checks.
module tb_counter_mod;

  localparam int N = 4;
  localparam int MODS [N] = '{10, 10, 10, 16};
  localparam int PRES [N] = '{1, 1, 3, 2};
  localparam int SATS [N] = '{0, 1, 0, 0};

  logic       clk;
  logic       nrst;
  logic       en;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] dv  [N];
  logic       dtc [N];
  logic       dov [N];

  int mv [N];
  int mp [N];
  int mo [N];

  int n_checks;
  int n_fail;
  bit chk_on;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  counter_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(1), .SATURATE(0)) u_a (
    .clk(clk), .nrst(nrst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .val(dv[0]), .tc(dtc[0]), .ovf(dov[0]));
  counter_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(1), .SATURATE(1)) u_b (
    .clk(clk), .nrst(nrst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .val(dv[1]), .tc(dtc[1]), .ovf(dov[1]));
  counter_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(3), .SATURATE(0)) u_c (
    .clk(clk), .nrst(nrst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .val(dv[2]), .tc(dtc[2]), .ovf(dov[2]));
  counter_mod #(.WIDTH(4), .MODULO(16), .PRESCALE(2), .SATURATE(0)) u_d (
    .clk(clk), .nrst(nrst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .val(dv[3]), .tc(dtc[3]), .ovf(dov[3]));

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t got=%0d expected=%0d", nm, idx, $time, act, exp);
    end
  endtask

  // behavioural model: apply the counting rules to integers at each edge
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!nrst || clr) begin
        mv[i] = 0; mp[i] = 0; mo[i] = 0;
      end else if (load) begin
        mv[i] = (int'(load_val) < MODS[i]) ? int'(load_val) : MODS[i] - 1;
        mp[i] = 0; mo[i] = 0;
      end else if (!en) begin
        mo[i] = 0;
      end else if (mp[i] < PRES[i] - 1) begin
        mp[i] = mp[i] + 1; mo[i] = 0;
      end else begin
        mp[i] = 0;
        if (up_dn) begin
          mo[i] = (mv[i] == MODS[i] - 1) ? 1 : 0;
          if (mo[i] == 0) mv[i] = mv[i] + 1;
          else if (SATS[i] == 0) mv[i] = 0;
        end else begin
          mo[i] = (mv[i] == 0) ? 1 : 0;
          if (mo[i] == 0) mv[i] = mv[i] - 1;
          else if (SATS[i] == 0) mv[i] = MODS[i] - 1;
        end
      end
    end
  end

  // scoreboard: compare every instance against the model away from the edge
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        chk("val", i, 32'(dv[i]), 32'(mv[i]));
        chk("ovf", i, 32'(dov[i]), 32'(mo[i]));
        chk("tc", i, 32'(dtc[i]),
            32'(up_dn ? (mv[i] == MODS[i] - 1) : (mv[i] == 0)));
      end
    end
  end

  // driver: apply one cycle of inputs, return just after the edge
  task automatic cyc(input logic e, input logic u, input logic c, input logic l,
                     input logic [3:0] lv);
    en = e; up_dn = u; clr = c; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; chk_on = 0;
    nrst = 1'b0; en = 0; up_dn = 0; clr = 0; load = 0; load_val = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_on = 1;
    chk("reset_val", 0, 32'(dv[0]), 0);
    chk("reset_ovf", 0, 32'(dov[0]), 0);
    chk("reset_tc_down", 0, 32'(dtc[0]), 1);
    nrst = 1'b1;

    // reset while counting, then an nrst glitch between edges is ignored
    for (int k = 0; k < 7; k++) cyc(1, 1, 0, 0, 0);
    chk("count_to_7", 0, 32'(dv[0]), 7);
    nrst = 1'b0;
    cyc(1, 1, 0, 0, 0);
    chk("reset_first_edge", 0, 32'(dv[0]), 0);
    cyc(1, 1, 0, 0, 0);
    nrst = 1'b1;
    en = 1; up_dn = 1;
    #1 nrst = 1'b0;
    #2 nrst = 1'b1;
    @(posedge clk); #1;
    chk("glitch_ignored", 0, 32'(dv[0]), 1);

    // up count through the wrap
    cyc(0, 1, 1, 0, 0);
    for (int k = 1; k <= 11; k++) begin
      cyc(1, 1, 0, 0, 0);
      chk("up_val", 0, 32'(dv[0]), 32'(k % 10));
      chk("up_tc", 0, 32'(dtc[0]), 32'(k == 9));
      chk("up_ovf", 0, 32'(dov[0]), 32'(k == 10));
    end

    // down count through zero
    cyc(0, 0, 1, 0, 0);
    chk("down_tc_at_0", 0, 32'(dtc[0]), 1);
    cyc(1, 0, 0, 0, 0);
    chk("down_wrap_val", 0, 32'(dv[0]), 9);
    chk("down_wrap_ovf", 0, 32'(dov[0]), 1);
    chk("down_tc_at_9", 0, 32'(dtc[0]), 0);
    cyc(1, 0, 0, 0, 0);
    chk("down_8", 0, 32'(dv[0]), 8);
    chk("down_8_ovf", 0, 32'(dov[0]), 0);
    cyc(1, 0, 0, 0, 0);
    chk("down_7", 0, 32'(dv[0]), 7);

    // saturate instance holds at 9 with ovf held high
    cyc(0, 1, 1, 0, 0);
    for (int k = 0; k < 12; k++) cyc(1, 1, 0, 0, 0);
    chk("sat_hold", 1, 32'(dv[1]), 9);
    chk("sat_ovf", 1, 32'(dov[1]), 1);

    // load clamp, load vs clear priority, hold with en low
    cyc(0, 1, 0, 1, 4'd12);
    chk("load_clamp", 0, 32'(dv[0]), 9);
    chk("load_full_range", 3, 32'(dv[3]), 12);
    cyc(1, 1, 1, 1, 4'd5);
    chk("clr_beats_load", 0, 32'(dv[0]), 0);
    cyc(0, 1, 0, 1, 4'd4);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("en_low_hold", 0, 32'(dv[0]), 4);

    // prescale by 3 with a two-cycle enable gap
    cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("pre_no_step", 2, 32'(dv[2]), 0);
    cyc(1, 1, 0, 0, 0);
    chk("pre_step1", 2, 32'(dv[2]), 1);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("pre_delayed", 2, 32'(dv[2]), 1);
    cyc(1, 1, 0, 0, 0);
    chk("pre_step2", 2, 32'(dv[2]), 2);

    // randomized traffic checked by the scoreboard
    for (int k = 0; k < 3000; k++) begin
      nrst = ($urandom_range(0, 99) != 0);
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
          4'($urandom_range(0, 15)));
    end
    nrst = 1'b1;
    cyc(0, 1, 0, 0, 0);

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
